left_writefifo_ctrl: RTL and testbench

Producer-side controller that writes the left-camera 8-bit pixel stream into the pixel FIFO drained by the left line-buffer reader. It frames the stream into IMG_WIDTH x IMG_HEIGHT images and drives writeEn / dataToFIFO with one-cycle registered latency. It respects FIFO full by dropping pixels, flags overflow and short frames, and reports row/column position and frame completion to the matching control logic.

---
 rtl/left_fifo_pkg.sv | 19 +
 rtl/pix_pos_counter.sv | 48 ++++
 rtl/left_writefifo_ctrl.sv | 145 ++++++++++++++
 tb/tb_left_writefifo_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/left_fifo_pkg.sv
// rtl/left_fifo_pkg.sv - shared types and geometry defaults for the left-camera FIFO writer
package left_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        STREAM   = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int IMG_WIDTH_DEF  = 256;
    localparam int IMG_HEIGHT_DEF = 200;
    localparam int DROP_CNT_W_DEF = 16;

    localparam int COL_W        = $clog2(IMG_WIDTH_DEF);
    localparam int ROW_W        = $clog2(IMG_HEIGHT_DEF);
    localparam int FRAME_PIXELS = IMG_WIDTH_DEF * IMG_HEIGHT_DEF;

endpackage

// File: rtl/pix_pos_counter.sv
// rtl/pix_pos_counter.sv - column/row position counter with line and frame wrap
module pix_pos_counter
    import left_fifo_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH_DEF,
    parameter int HEIGHT = IMG_HEIGHT_DEF,
    parameter int CW     = $clog2(WIDTH),
    parameter int RW     = $clog2(HEIGHT)
) (
    input  logic          clk,        // system clock
    input  logic          rst,        // synchronous, active-high reset
    input  logic          clear,      // restart at (0,0); takes effect this cycle
    input  logic          advance,    // consume the current slot
    output logic [CW-1:0] col,        // position of the current slot
    output logic [RW-1:0] row,
    output logic          line_end,   // current slot is the last of its line
    output logic          frame_last  // current slot is the last of the frame
);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    // A clear in the same cycle as an advance makes the current slot (0,0),
    // so the effective position is muxed before the wrap logic sees it.
    assign col        = clear ? '0 : col_q;
    assign row        = clear ? '0 : row_q;
    assign line_end   = (col == CW'(WIDTH - 1));
    assign frame_last = line_end && (row == RW'(HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (advance) begin
            if (line_end) begin
                col_q <= '0;
                row_q <= frame_last ? '0 : row + RW'(1);
            end else begin
                col_q <= col + CW'(1);
                row_q <= row;
            end
        end else if (clear) begin
            col_q <= '0;
            row_q <= '0;
        end
    end

endmodule

// File: rtl/left_writefifo_ctrl.sv
// rtl/left_writefifo_ctrl.sv - frames the left-camera pixel stream into the pixel FIFO
module left_writefifo_ctrl
    import left_fifo_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int DROP_CNT_W = DROP_CNT_W_DEF
) (
    input  logic                          clk,           // system clock
    input  logic                          rst,           // synchronous, active-high reset
    input  logic                          i_start,       // arm (sampled in IDLE)
    input  logic                          i_stop,        // go idle once the current frame completes
    input  logic                          i_clear,       // clear sticky flags and drop counter
    input  logic                          i_frame_start, // start-of-frame pulse
    input  logic                          i_pix_valid,   // pixel qualifier, no backpressure
    input  logic [7:0]                    i_pix,         // pixel data
    input  logic                          full,          // FIFO full
    output logic                          writeEn,       // FIFO write enable
    output logic [7:0]                    dataToFIFO,    // FIFO write data
    output logic [$clog2(IMG_WIDTH)-1:0]  o_col,         // column of last consumed slot
    output logic [$clog2(IMG_HEIGHT)-1:0] o_row,         // row of last consumed slot
    output logic                          o_line_end,    // pulse with last slot of a line
    output logic                          o_frame_done,  // pulse after last slot of a frame
    output logic                          o_busy,        // not IDLE
    output logic                          o_overflow,    // sticky: pixel dropped on full
    output logic                          o_err_short,   // sticky: SOF inside a frame
    output logic [DROP_CNT_W-1:0]         o_drop_count   // saturating dropped-pixel count
);

    localparam int COL_BITS = $clog2(IMG_WIDTH);
    localparam int ROW_BITS = $clog2(IMG_HEIGHT);

    state_t state;
    logic   stop_seen;

    logic                  cnt_clear;
    logic                  take;
    logic [COL_BITS-1:0]   cur_col;
    logic [ROW_BITS-1:0]   cur_row;
    logic                  cur_line_end;
    logic                  cur_frame_last;
    logic [DROP_CNT_W-1:0] drop_base;
    logic [DROP_CNT_W-1:0] drop_next;

    // SOF restarts geometry both when arming a frame and when truncating one.
    assign cnt_clear = i_frame_start && (state == WAIT_SOF || state == STREAM);
    // A pixel is a slot in STREAM, or in WAIT_SOF only when it rides on the SOF.
    assign take      = i_pix_valid && ((state == STREAM) || (state == WAIT_SOF && i_frame_start));

    // A clear coinciding with a drop restarts the count from zero before the
    // drop is added, so the drop is never lost.
    assign drop_base = i_clear ? '0 : o_drop_count;
    assign drop_next = (&drop_base) ? drop_base : drop_base + DROP_CNT_W'(1);

    pix_pos_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT),
        .CW     (COL_BITS),
        .RW     (ROW_BITS)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .advance    (take),
        .col        (cur_col),
        .row        (cur_row),
        .line_end   (cur_line_end),
        .frame_last (cur_frame_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            stop_seen    <= 1'b0;
            writeEn      <= 1'b0;
            dataToFIFO   <= '0;
            o_col        <= '0;
            o_row        <= '0;
            o_line_end   <= 1'b0;
            o_frame_done <= 1'b0;
            o_busy       <= 1'b0;
            o_overflow   <= 1'b0;
            o_err_short  <= 1'b0;
            o_drop_count <= '0;
        end else begin
            writeEn      <= 1'b0;
            o_line_end   <= 1'b0;
            o_frame_done <= 1'b0;

            if (i_clear) begin
                o_overflow   <= 1'b0;
                o_err_short  <= 1'b0;
                o_drop_count <= '0;
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        state     <= WAIT_SOF;
                        o_busy    <= 1'b1;
                        stop_seen <= 1'b0;
                    end
                end
                WAIT_SOF: begin
                    if (i_stop) stop_seen <= 1'b1;
                    if (i_frame_start) state <= STREAM;
                end
                STREAM: begin
                    if (i_stop) stop_seen <= 1'b1;
                    if (i_frame_start) o_err_short <= 1'b1;
                end
                DONE: begin
                    o_frame_done <= 1'b1;
                    stop_seen    <= 1'b0;
                    if (stop_seen || i_stop) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        state  <= WAIT_SOF;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase

            // Dropped slots still report position and line_end so the
            // downstream geometry stays aligned with the camera.
            if (take) begin
                writeEn    <= ~full;
                dataToFIFO <= i_pix;
                o_col      <= cur_col;
                o_row      <= cur_row;
                o_line_end <= cur_line_end;
                if (full) begin
                    o_overflow   <= 1'b1;
                    o_drop_count <= drop_next;
                end
                if (cur_frame_last) state <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_left_writefifo_ctrl.sv
// tb/tb_left_writefifo_ctrl.sv - scoreboard bench for left_writefifo_ctrl
module tb_left_writefifo_ctrl;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int DW   = 3;
    localparam int DMAX = (1 << DW) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_WAIT   = 1;
    localparam int M_STREAM = 2;
    localparam int M_DONE   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start, i_stop, i_clear, i_frame_start, i_pix_valid, full;
    logic [7:0]    i_pix;
    logic          writeEn;
    logic [7:0]    dataToFIFO;
    logic [1:0]    o_col;
    logic [1:0]    o_row;
    logic          o_line_end, o_frame_done, o_busy, o_overflow, o_err_short;
    logic [DW-1:0] o_drop_count;

    left_writefifo_ctrl #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DROP_CNT_W (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_clear       (i_clear),
        .i_frame_start (i_frame_start),
        .i_pix_valid   (i_pix_valid),
        .i_pix         (i_pix),
        .full          (full),
        .writeEn       (writeEn),
        .dataToFIFO    (dataToFIFO),
        .o_col         (o_col),
        .o_row         (o_row),
        .o_line_end    (o_line_end),
        .o_frame_done  (o_frame_done),
        .o_busy        (o_busy),
        .o_overflow    (o_overflow),
        .o_err_short   (o_err_short),
        .o_drop_count  (o_drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   c;
        bit   we;
        int   d;
        int   col;
        int   row;
        bit   le;
    } wr_t;

    typedef struct {
        int c;
        bit ovf;
        bit es;
        int drop;
        bit busy;
    } st_t;

    wr_t wq[$];
    st_t sq[$];
    int  fdq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model state: frame pixel index k gives the geometry directly
    int m_mode    = M_IDLE;
    int k         = 0;
    bit m_ovf     = 0;
    bit m_es      = 0;
    int m_drop    = 0;
    bit m_stop    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic slot(input int c);
        wr_t w;
        w.c   = c;
        w.we  = !full;
        w.d   = int'(i_pix);
        w.col = k % W;
        w.row = k / W;
        w.le  = ((k % W) == W - 1);
        wq.push_back(w);
        if (full) begin
            m_ovf = 1;
            if (m_drop < DMAX) m_drop++;
        end
        k++;
        if (k == W * H) m_mode = M_DONE;
    endtask

    task automatic model_step();
        int  c;
        st_t s;
        c = cyc + 1;
        if (rst) begin
            m_mode = M_IDLE;
            m_ovf  = 0;
            m_es   = 0;
            m_drop = 0;
            m_stop = 0;
            k      = 0;
        end else begin
            if (i_clear) begin
                m_ovf  = 0;
                m_es   = 0;
                m_drop = 0;
            end
            case (m_mode)
                M_IDLE: if (i_start) begin
                    m_mode = M_WAIT;
                    m_stop = 0;
                end
                M_WAIT: begin
                    if (i_stop) m_stop = 1;
                    if (i_frame_start) begin
                        m_mode = M_STREAM;
                        k = 0;
                        if (i_pix_valid) slot(c);
                    end
                end
                M_STREAM: begin
                    if (i_stop) m_stop = 1;
                    if (i_frame_start) begin
                        m_es = 1;
                        k = 0;
                    end
                    if (i_pix_valid) slot(c);
                end
                default: begin
                    fdq.push_back(c);
                    m_mode = (m_stop || i_stop) ? M_IDLE : M_WAIT;
                    m_stop = 0;
                end
            endcase
        end
        s.c    = c;
        s.ovf  = m_ovf;
        s.es   = m_es;
        s.drop = m_drop;
        s.busy = (m_mode != M_IDLE);
        sq.push_back(s);
    endtask

    task automatic drv(input bit r, input bit st, input bit sp, input bit cl,
                       input bit sof, input bit v, input int d, input bit f);
        rst           = r;
        i_start       = st;
        i_stop        = sp;
        i_clear       = cl;
        i_frame_start = sof;
        i_pix_valid   = v;
        i_pix         = 8'(d);
        full          = f;
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame_pixels(input int n, input int base, input int f_lo,
                                input int f_hi, input int stop_at);
        for (int i = 0; i < n; i++)
            drv(0, 0, (i == stop_at), 0, 0, 1, base + i, (i >= f_lo && i <= f_hi));
    endtask

    // monitor: pops the per-edge expectations and compares after each edge
    initial begin
        st_t s;
        wr_t w;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (sq.size() > 0 && sq[0].c == cyc) begin
                s = sq.pop_front();
                chk("overflow",   int'(o_overflow),   int'(s.ovf));
                chk("err_short",  int'(o_err_short),  int'(s.es));
                chk("drop_count", int'(o_drop_count), s.drop);
                chk("busy",       int'(o_busy),       int'(s.busy));
                if (wq.size() > 0 && wq[0].c == cyc) begin
                    w = wq.pop_front();
                    chk("writeEn",  int'(writeEn),    int'(w.we));
                    chk("line_end", int'(o_line_end), int'(w.le));
                    chk("col",      int'(o_col),      w.col);
                    chk("row",      int'(o_row),      w.row);
                    if (w.we) chk("data", int'(dataToFIFO), w.d);
                end else begin
                    chk("writeEn_idle",  int'(writeEn),    0);
                    chk("line_end_idle", int'(o_line_end), 0);
                end
                if (fdq.size() > 0 && fdq[0] == cyc) begin
                    void'(fdq.pop_front());
                    chk("frame_done", int'(o_frame_done), 1);
                end else begin
                    chk("frame_done_idle", int'(o_frame_done), 0);
                end
            end
        end
    end

    initial begin
        rst = 1; i_start = 0; i_stop = 0; i_clear = 0;
        i_frame_start = 0; i_pix_valid = 0; i_pix = 0; full = 0;
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // clean frame
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 0, 0);
        frame_pixels(12, 0, -1, -1, -1);
        idle(3);

        // drops on pixels 5 and 6, then clear
        drv(0, 0, 0, 0, 1, 0, 0, 0);
        frame_pixels(12, 0, 5, 6, -1);
        idle(3);
        drv(0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);

        // truncated frame: SOF with pixel (0,0) after pixel 6
        drv(0, 0, 0, 0, 1, 0, 0, 0);
        frame_pixels(7, 8'h20, -1, -1, -1);
        drv(0, 0, 0, 0, 1, 1, 8'h40, 0);
        frame_pixels(11, 8'h41, -1, -1, -1);
        idle(3);
        drv(0, 0, 0, 1, 0, 0, 0, 0);

        // pixels with no SOF are ignored
        frame_pixels(5, 8'h50, -1, -1, -1);
        idle(2);

        // stop mid-frame, then SOF while idle is ignored
        drv(0, 0, 0, 0, 1, 0, 0, 0);
        frame_pixels(12, 8'h60, -1, -1, 4);
        idle(3);
        drv(0, 0, 0, 0, 1, 1, 8'h70, 0);
        frame_pixels(4, 8'h71, -1, -1, -1);
        idle(2);

        // reset at pixel 7, then a full frame
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 0, 0);
        frame_pixels(7, 8'h80, -1, -1, -1);
        drv(1, 0, 0, 0, 0, 1, 8'h87, 0);
        idle(1);
        drv(0, 1, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 0, 0);
        frame_pixels(12, 8'h90, -1, -1, -1);
        idle(3);

        // drop counter saturation, then clear coinciding with a drop
        drv(0, 0, 0, 0, 1, 0, 0, 0);
        frame_pixels(12, 8'hA0, 0, 11, -1);
        idle(3);
        drv(0, 0, 0, 1, 1, 1, 8'hB0, 1);
        frame_pixels(11, 8'hB1, -1, -1, -1);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drv(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 255)),
                ($urandom_range(0, 4) == 0));
        end
        idle(5);

        chk("wq_drained",  wq.size(),  0);
        chk("fdq_drained", fdq.size(), 0);
        chk("sq_drained",  sq.size(),  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
